alu_uart_frontend: RTL and testbench
====================================

# alu_uart_frontend

Sequential front end that sits between the UART receiver/transmitter and the combinational `alu` stage. It assembles three received bytes (operand A, operand B, opcode) into registered ALU inputs and waits one cycle for the ALU to settle. It then captures the ALU result and returns it to the host as two UART bytes, sign-extended to 16 bits, low byte first.

## Interface
- `NB_DATA`, 8, operand width. Legal range 1..8; the operand is taken from the low bits of the received byte.
- `NB_OP`, 6, opcode width. Legal range 1..8; the opcode is taken from the low bits of the received byte.
- `TIMEOUT_CYC`, 1_000_000, inter-byte timeout in clock cycles. Value 0 disables the timeout.

Ports:
- `i_clk`  in  1  single clock; all state changes on its rising edge.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_rx_data`  in  8  received byte; valid only while `i_rx_done`=1.
- `i_rx_done`  in  1  one-cycle strobe from the UART receiver.
- `o_data_a`  out  NB_DATA  registered operand A to the ALU.
- `o_data_b`  out  NB_DATA  registered operand B to the ALU.
- `o_op`  out  NB_OP  registered opcode to the ALU.
- `i_alu_res`  in  NB_DATA+1  signed result from the ALU.
- `o_tx_data`  out  8  byte to the UART transmitter.
- `o_tx_start`  out  1  one-cycle request to start transmitting `o_tx_data`.
- `i_tx_done`  in  1  one-cycle strobe from the transmitter when its byte has finished.
- `o_busy`  out  1  high from CALC through WAIT_HI.

## Operation
- FSM states: WAIT_A, WAIT_B, WAIT_OP, CALC, SEND_LO, WAIT_LO, SEND_HI, WAIT_HI.
- WAIT_A: on `i_rx_done`, load `o_data_a` from `i_rx_data[NB_DATA-1:0]` and go to WAIT_B.
- WAIT_B: on `i_rx_done`, load `o_data_b` and go to WAIT_OP.
- WAIT_OP: on `i_rx_done`, load `o_op` from `i_rx_data[NB_OP-1:0]` and go to CALC.
- CALC: lasts exactly one cycle.
  - Register `res_q` = `i_alu_res` sign-extended to 16 bits.
  - Go to SEND_LO.
- SEND_LO: drive `o_tx_start`=1 and `o_tx_data`=`res_q[7:0]` for one cycle, then go to WAIT_LO.
- WAIT_LO: on `i_tx_done`, go to SEND_HI.
- SEND_HI: drive `o_tx_start`=1 and `o_tx_data`=`res_q[15:8]` for one cycle, then go to WAIT_HI.
- WAIT_HI: on `i_tx_done`, go to WAIT_A.
- `o_data_a`, `o_data_b` and `o_op` hold their last loaded values until overwritten. They are not cleared by a timeout or by the end of a frame.
- `i_rx_done` is ignored (byte dropped) in CALC through WAIT_HI.
- `i_tx_done` is ignored outside WAIT_LO and WAIT_HI.
- Timeout:
  - A cycle counter clears on every accepted byte and counts while in WAIT_B or WAIT_OP.
  - When it reaches `TIMEOUT_CYC` with no `i_rx_done`, go to WAIT_A (partial frame discarded).
  - There is no timeout in the TX wait states.
- Simultaneous events: `i_rx_done` in the same cycle as timeout expiry means the byte is accepted and the timeout does not fire.
- Reset, asynchronous and valid in any state:
  - State returns to WAIT_A.
  - All outputs and `res_q` go to 0.
  - `o_tx_start` deasserts immediately.

## Timing
- The opcode byte's `i_rx_done` is sampled at edge N:
  - `o_op` is valid after edge N.
  - The ALU result is captured at edge N+1 (end of CALC).
  - `o_tx_start` is high in the cycle following edge N+1.
- The second `o_tx_start` is high in the cycle after the edge that samples the first `i_tx_done`.
- `o_tx_data` is held stable from the `o_tx_start` cycle until the matching `i_tx_done`.
- `o_tx_start` is never high for more than one consecutive cycle.
- `o_busy` is registered with the state; it is high in the cycles the state is CALC..WAIT_HI.
- Minimum frame turnaround: 3 RX strobes + 1 CALC cycle + two TX transactions.

## Test plan
- ADD: bytes 0x05, 0x03, 0x20 → `o_tx_start` high 2 cycles after the third strobe. Then `o_tx_data`=0x08; after `i_tx_done`, `o_tx_data`=0x00.
- SUB, negative result: bytes 0x03, 0x05, 0x22 → transmitted bytes 0xFE, then 0xFF.
- Overflow into bit NB_DATA: bytes 0x7F, 0x7F, 0x20 → 9-bit result 0x0FE, transmitted bytes 0xFE, 0x00.
- Timeout with `TIMEOUT_CYC`=16: send 0x11, then no strobe for 16 cycles → state returns to WAIT_A and `o_data_a` stays 0x11. Next bytes 0x01, 0x02, 0x20 → transmitted bytes 0x03, 0x00.
- Dropped RX and spurious TX done: pulse `i_rx_done` (byte 0x55) during WAIT_LO → ignored. Pulse `i_tx_done` in WAIT_A → no state change. Register values are unchanged in both cases.
- Reset mid-transmission: assert `i_rst_n`=0 in WAIT_LO → all outputs 0 and `o_busy`=0 immediately, no further `o_tx_start`. After release, a new frame works normally.

Source files
------------

// File: rtl/alu_uart_frontend_if.sv
// Signal bundle between the UART/ALU environment and alu_uart_frontend.
// The master side is the frontend itself; the slave side is UART receiver, transmitter and ALU.
interface alu_uart_frontend_if #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
);
  logic [7:0]               i_rx_data;
  logic                     i_rx_done;
  logic [NB_DATA-1:0]       o_data_a;
  logic [NB_DATA-1:0]       o_data_b;
  logic [NB_OP-1:0]         o_op;
  logic signed [NB_DATA:0]  i_alu_res;
  logic [7:0]               o_tx_data;
  logic                     o_tx_start;
  logic                     i_tx_done;
  logic                     o_busy;

  modport master (
    input  i_rx_data, i_rx_done, i_alu_res, i_tx_done,
    output o_data_a, o_data_b, o_op, o_tx_data, o_tx_start, o_busy
  );

  modport slave (
    output i_rx_data, i_rx_done, i_alu_res, i_tx_done,
    input  o_data_a, o_data_b, o_op, o_tx_data, o_tx_start, o_busy
  );
endinterface

// File: rtl/alu_uart_frontend.sv
// Collects operand A, operand B and opcode bytes from the UART, lets the ALU settle one
// cycle, then returns the sign-extended 16-bit result as two bytes, low byte first.
module alu_uart_frontend #(
  parameter int NB_DATA     = 8,
  parameter int NB_OP       = 6,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  alu_uart_frontend_if.master  bus
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  typedef enum logic [2:0] {
    WAIT_A, WAIT_B, WAIT_OP, CALC, SEND_LO, WAIT_LO, SEND_HI, WAIT_HI
  } state_t;

  state_t             state_q, state_d;
  logic [NB_DATA-1:0] data_a_q, data_b_q;
  logic [NB_OP-1:0]   op_q;
  logic [15:0]        res_q;
  logic [15:0]        res_ext;
  logic [7:0]         tx_data_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               accept;
  logic               timeout_hit;

  assign accept      = bus.i_rx_done && (state_q inside {WAIT_A, WAIT_B, WAIT_OP});
  // A byte arriving in the expiry cycle wins over the timeout.
  assign timeout_hit = (TIMEOUT_CYC != 0) && (state_q inside {WAIT_B, WAIT_OP})
                       && !bus.i_rx_done && (cnt_q == CNT_LAST);
  assign res_ext     = {{(15 - NB_DATA){bus.i_alu_res[NB_DATA]}}, bus.i_alu_res};

  // NOTE: next state gets its default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT_A:  if (bus.i_rx_done) state_d = WAIT_B;
      WAIT_B:  if (bus.i_rx_done) state_d = WAIT_OP;
               else if (timeout_hit) state_d = WAIT_A;
      WAIT_OP: if (bus.i_rx_done) state_d = CALC;
               else if (timeout_hit) state_d = WAIT_A;
      CALC:    state_d = SEND_LO;
      SEND_LO: state_d = WAIT_LO;
      WAIT_LO: if (bus.i_tx_done) state_d = SEND_HI;
      SEND_HI: state_d = WAIT_HI;
      WAIT_HI: if (bus.i_tx_done) state_d = WAIT_A;
      default: state_d = WAIT_A;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= WAIT_A;
    else          state_q <= state_d;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_a_q  <= '0;
      data_b_q  <= '0;
      op_q      <= '0;
      res_q     <= '0;
      tx_data_q <= '0;
      cnt_q     <= '0;
    end else begin
      if (accept && state_q == WAIT_A)  data_a_q <= bus.i_rx_data[NB_DATA-1:0];
      if (accept && state_q == WAIT_B)  data_b_q <= bus.i_rx_data[NB_DATA-1:0];
      if (accept && state_q == WAIT_OP) op_q     <= bus.i_rx_data[NB_OP-1:0];

      // tx_data is loaded one edge early so it is stable for the whole byte transfer.
      if (state_q == CALC) begin
        res_q     <= res_ext;
        tx_data_q <= res_ext[7:0];
      end else if (state_q == WAIT_LO && bus.i_tx_done) begin
        tx_data_q <= res_q[15:8];
      end

      if (accept || timeout_hit)               cnt_q <= '0;
      else if (state_q inside {WAIT_B, WAIT_OP}) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.o_data_a   = data_a_q;
  assign bus.o_data_b   = data_b_q;
  assign bus.o_op       = op_q;
  assign bus.o_tx_data  = tx_data_q;
  assign bus.o_tx_start = (state_q == SEND_LO) || (state_q == SEND_HI);
  assign bus.o_busy     = state_q inside {CALC, SEND_LO, WAIT_LO, SEND_HI, WAIT_HI};

endmodule

// File: tb/tb_alu_uart_frontend.sv
// Randomised bench for alu_uart_frontend with a stand-in ALU and a frame-level reference model.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_alu_uart_frontend;

  localparam int NB_DATA = 8;
  localparam int NB_OP   = 6;
  localparam int TO_CYC  = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   m_a, m_b, m_op;

  always #5 clk = ~clk;

  alu_uart_frontend_if #(.NB_DATA(NB_DATA), .NB_OP(NB_OP)) bus ();

  alu_uart_frontend #(.NB_DATA(NB_DATA), .NB_OP(NB_OP), .TIMEOUT_CYC(TO_CYC)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  // Stand-in combinational ALU: signed operands, MIPS-style function codes.
  logic signed [NB_DATA:0] alu_sa, alu_sb;
  always_comb begin
    alu_sa = {bus.o_data_a[NB_DATA-1], bus.o_data_a};
    alu_sb = {bus.o_data_b[NB_DATA-1], bus.o_data_b};
    bus.i_alu_res = '0;
    case (bus.o_op)
      6'h20: bus.i_alu_res = alu_sa + alu_sb;
      6'h22: bus.i_alu_res = alu_sa - alu_sb;
      6'h24: bus.i_alu_res = alu_sa & alu_sb;
      6'h25: bus.i_alu_res = alu_sa | alu_sb;
      6'h26: bus.i_alu_res = alu_sa ^ alu_sb;
      6'h27: bus.i_alu_res = ~(alu_sa | alu_sb);
      default: bus.i_alu_res = '0;
    endcase
  end

  // Expected 16-bit reply for a frame, computed with plain integer arithmetic.
  function automatic int ref_reply(input int a_byte, input int b_byte, input int op_byte);
    int a, b, r;
    a = a_byte & 255; if (a >= 128) a -= 256;
    b = b_byte & 255; if (b >= 128) b -= 256;
    case (op_byte & 63)
      32:      r = a + b;
      34:      r = a - b;
      36:      r = a & b;
      37:      r = a | b;
      38:      r = a ^ b;
      39:      r = ~(a | b);
      default: r = 0;
    endcase
    return r & 16'hFFFF;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.i_rx_data = b;
    bus.i_rx_done = 1'b1;
    tick();
    bus.i_rx_done = 1'b0;
    bus.i_rx_data = 8'($urandom);
  endtask

  task automatic pulse_tx_done();
    bus.i_tx_done = 1'b1;
    tick();
    bus.i_tx_done = 1'b0;
  endtask

  task automatic regs_match(input string tag);
    check({tag, "_a"},  32'(bus.o_data_a), 32'(m_a));
    check({tag, "_b"},  32'(bus.o_data_b), 32'(m_b));
    check({tag, "_op"}, 32'(bus.o_op),     32'(m_op));
  endtask

  // Full frame: three bytes with 'gap' idle cycles between them, then both TX bytes.
  task automatic run_frame(input int a, input int b, input int op, input int gap, input bit poke_rx);
    int exp, n, d;
    send_byte(8'(a)); m_a = a & 255;
    repeat (gap) tick();
    send_byte(8'(b)); m_b = b & 255;
    repeat (gap) tick();
    send_byte(8'(op)); m_op = op & 63;
    exp = ref_reply(a, b, op);
    regs_match("load");
    check("calc_busy", 32'(bus.o_busy), 32'd1);
    n = 0;
    while (!bus.o_tx_start && n < 8) begin tick(); n++; end
    check("lo_latency", 32'(n), 32'd1);
    check("lo_data", 32'(bus.o_tx_data), 32'(exp & 255));
    tick();
    check("lo_pulse", 32'(bus.o_tx_start), 32'd0);
    d = $urandom_range(0, 3);
    repeat (d) tick();
    if (poke_rx) begin
      send_byte(8'h55);
      regs_match("drop");
    end
    check("lo_hold", 32'(bus.o_tx_data), 32'(exp & 255));
    check("lo_busy", 32'(bus.o_busy), 32'd1);
    pulse_tx_done();
    check("hi_start", 32'(bus.o_tx_start), 32'd1);
    check("hi_data", 32'(bus.o_tx_data), 32'(exp >> 8));
    tick();
    check("hi_pulse", 32'(bus.o_tx_start), 32'd0);
    repeat ($urandom_range(0, 3)) tick();
    pulse_tx_done();
    check("end_busy", 32'(bus.o_busy), 32'd0);
    check("end_hold", 32'(bus.o_tx_data), 32'(exp >> 8));
  endtask

  initial begin
    int ops[6] = '{32'h20, 32'h22, 32'h24, 32'h25, 32'h26, 32'h27};
    int n;
    bus.i_rx_data = '0;
    bus.i_rx_done = 1'b0;
    bus.i_tx_done = 1'b0;
    rst_n = 1'b0;
    m_a = 0; m_b = 0; m_op = 0;
    #12;
    regs_match("reset");
    check("reset_tx_data", 32'(bus.o_tx_data), 32'd0);
    check("reset_start", 32'(bus.o_tx_start), 32'd0);
    check("reset_busy", 32'(bus.o_busy), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    run_frame(8'h05, 8'h03, 8'h20, 0, 1'b0);  // ADD -> 0x08, 0x00
    run_frame(8'h03, 8'h05, 8'h22, 0, 1'b0);  // SUB -> 0xFE, 0xFF
    run_frame(8'h7F, 8'h7F, 8'h20, 0, 1'b0);  // overflow into bit 8 -> 0xFE, 0x00
    run_frame(8'h80, 8'h80, 8'h20, 0, 1'b0);  // most negative sum -> 0x00, 0xFF
    run_frame(8'hA5, 8'h0F, 8'hE6, 1, 1'b1);  // opcode upper bits discarded, dropped RX byte

    // Timeout: 16 idle cycles after operand A returns to WAIT_A with A retained.
    send_byte(8'h11); m_a = 8'h11;
    repeat (TO_CYC) tick();
    check("to_busy", 32'(bus.o_busy), 32'd0);
    regs_match("to_hold");
    run_frame(8'h01, 8'h02, 8'h20, 0, 1'b0);
    // Gaps just short of the timeout keep the frame alive.
    run_frame(8'h21, 8'h22, 8'h22, TO_CYC - 2, 1'b0);

    // Spurious TX done while idle.
    pulse_tx_done();
    check("spur_start", 32'(bus.o_tx_start), 32'd0);
    check("spur_busy", 32'(bus.o_busy), 32'd0);
    regs_match("spur");

    // Reset while waiting for the low byte to finish.
    send_byte(8'h09); send_byte(8'h04); send_byte(8'h20);
    n = 0;
    while (!bus.o_tx_start && n < 8) begin tick(); n++; end
    tick();
    #2 rst_n = 1'b0;
    #1;
    m_a = 0; m_b = 0; m_op = 0;
    regs_match("rst_mid");
    check("rst_tx_data", 32'(bus.o_tx_data), 32'd0);
    check("rst_start", 32'(bus.o_tx_start), 32'd0);
    check("rst_busy", 32'(bus.o_busy), 32'd0);
    tick();
    pulse_tx_done();
    rst_n = 1'b1;
    n = 0;
    repeat (6) begin tick(); if (bus.o_tx_start) n++; end
    check("rst_no_start", 32'(n), 32'd0);
    run_frame(8'h10, 8'h20, 8'h20, 0, 1'b0);

    // Random frames.
    for (int i = 0; i < 24; i++) begin
      int op;
      op = ops[$urandom_range(0, 5)];
      if ($urandom_range(0, 3) == 0) op = op | (int'($urandom_range(0, 3)) << 6);
      else if ($urandom_range(0, 7) == 0) op = $urandom_range(0, 255);
      run_frame($urandom_range(0, 255), $urandom_range(0, 255), op,
                $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
